// File: rtl/la_pkg.sv
// Shared types for the logic-analyser capture core: FSM states and trigger modes.
package la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT,
    ST_POST,
    ST_DONE
  } la_state_e;

  typedef enum logic [1:0] {
    TM_LEVEL = 2'd0,
    TM_RISE  = 2'd1,
    TM_FALL  = 2'd2,
    TM_IMM   = 2'd3
  } la_trig_mode_e;

endpackage

// File: rtl/la_capture_ram.sv
// Simple dual-port sample store: write lands on the clock edge, read data is registered (1 cycle).
// No backpressure; the core guarantees reads and writes never share a cycle.
module la_capture_ram #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/la_capture_core.sv
// Circular-buffer capture with mask/value trigger, pre-trigger depth and indexed readout.
// One sample per clock, read latency 2; no backpressure, reads only honoured once capture is DONE.
module la_capture_core
  import la_pkg::*;
#(
  parameter int DATA_W = 5,
  parameter int TRIG_W = 1,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [TRIG_W-1:0] trig_mask_i,
  input  logic [TRIG_W-1:0] trig_value_i,
  input  logic [AW-1:0]     pre_cnt_i,
  output logic              armed_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [AW-1:0]     trig_addr_o,
  input  logic              rd_req_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o
);

  la_state_e     r_state;
  la_trig_mode_e r_mode;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_pre;
  logic [AW-1:0] r_trig_addr;
  logic          r_armed;
  logic          r_done;
  logic          r_triggered;
  logic          r_prev_match;

  logic              r_rd_vld1;
  logic              r_rd_vld;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_match;
  logic              w_trig;
  logic              w_we;
  logic              w_rd_ok;
  logic [AW-1:0]     w_post_len;
  logic [AW-1:0]     w_raddr;
  logic [DATA_W-1:0] w_ram_q;

  assign w_match = ((trig_i ^ trig_value_i) & trig_mask_i) == '0;
  assign w_we    = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
  // DEPTH-1 is all ones in AW bits, so DEPTH-1-pre is the bitwise inverse.
  assign w_post_len = ~r_pre;

  always_comb begin
    w_trig = 1'b0;
    case (r_mode)
      TM_LEVEL: w_trig = w_match;
      TM_RISE:  w_trig = w_match && !r_prev_match;
      TM_FALL:  w_trig = !w_match && r_prev_match;
      TM_IMM:   w_trig = 1'b1;
      default:  w_trig = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_mode       <= TM_LEVEL;
      r_wr_ptr     <= '0;
      r_cnt        <= '0;
      r_pre        <= '0;
      r_trig_addr  <= '0;
      r_armed      <= 1'b0;
      r_done       <= 1'b0;
      r_triggered  <= 1'b0;
      r_prev_match <= 1'b0;
    end else begin
      r_prev_match <= w_match;
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (arm_i) begin
        r_pre       <= pre_cnt_i;
        r_mode      <= la_trig_mode_e'(trig_mode_i);
        r_wr_ptr    <= '0;
        r_cnt       <= '0;
        r_done      <= 1'b0;
        r_triggered <= 1'b0;
        r_armed     <= 1'b1;
        r_state     <= (pre_cnt_i != '0) ? ST_PRE : ST_WAIT;
      end else if (abort_i && w_we) begin
        r_state     <= ST_IDLE;
        r_armed     <= 1'b0;
        r_done      <= 1'b0;
        r_triggered <= 1'b0;
      end else begin
        case (r_state)
          ST_PRE: begin
            r_cnt <= r_cnt + AW'(1);
            if (r_cnt == r_pre - AW'(1)) begin
              r_state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (w_trig) begin
              r_trig_addr <= r_wr_ptr;
              r_triggered <= 1'b1;
              r_cnt       <= '0;
              if (w_post_len == '0) begin
                r_state <= ST_DONE;
                r_armed <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_POST;
              end
            end
          end
          ST_POST: begin
            r_cnt <= r_cnt + AW'(1);
            if (r_cnt == w_post_len - AW'(1)) begin
              r_state <= ST_DONE;
              r_armed <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Logical index 0 is the oldest sample, pre_cnt samples before the trigger.
  assign w_raddr = r_trig_addr - r_pre + rd_addr_i;
  assign w_rd_ok = rd_req_i && (r_state == ST_DONE) && !arm_i;

  la_capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .i_clk   (clk_i),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_i),
    .i_re    (w_rd_ok),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_rd_vld1 <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_vld1 <= w_rd_ok;
      r_rd_vld  <= r_rd_vld1 && !arm_i;
      if (r_rd_vld1) begin
        r_rd_data <= w_ram_q;
      end
    end
  end

  assign armed_o     = r_armed;
  assign done_o      = r_done;
  assign triggered_o = r_triggered;
  assign trig_addr_o = r_trig_addr;
  assign rd_valid_o  = r_rd_vld;
  assign rd_data_o   = r_rd_data;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core at DATA_W=5, TRIG_W=1, DEPTH=16; sample data is a counter from 0 after arm.
module tb_la_capture_core;

  localparam int DATA_W = 5;
  localparam int TRIG_W = 1;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [DATA_W-1:0] data_i;
  logic [TRIG_W-1:0] trig_i;
  logic              arm_i;
  logic              abort_i;
  logic [1:0]        trig_mode_i;
  logic [TRIG_W-1:0] trig_mask_i;
  logic [TRIG_W-1:0] trig_value_i;
  logic [AW-1:0]     pre_cnt_i;
  logic              armed_o;
  logic              triggered_o;
  logic              done_o;
  logic [AW-1:0]     trig_addr_o;
  logic              rd_req_i;
  logic [AW-1:0]     rd_addr_i;
  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;

  int n_chk  = 0;
  int n_pass = 0;

  la_capture_core #(
    .DATA_W (DATA_W),
    .TRIG_W (TRIG_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .data_i       (data_i),
    .trig_i       (trig_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .trig_mode_i  (trig_mode_i),
    .trig_mask_i  (trig_mask_i),
    .trig_value_i (trig_value_i),
    .pre_cnt_i    (pre_cnt_i),
    .armed_o      (armed_o),
    .triggered_o  (triggered_o),
    .done_o       (done_o),
    .trig_addr_o  (trig_addr_o),
    .rd_req_i     (rd_req_i),
    .rd_addr_i    (rd_addr_i),
    .rd_valid_o   (rd_valid_o),
    .rd_data_o    (rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance one rising edge and sample 1 ns after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [AW-1:0] pre);
    trig_mode_i = mode;
    pre_cnt_i   = pre;
    arm_i       = 1'b1;
    step();
    arm_i       = 1'b0;
    trig_mode_i = 2'd0;
    pre_cnt_i   = '0;
    data_i      = '0;
  endtask

  task automatic rd_one(input string tag, input logic [AW-1:0] addr, input logic [DATA_W-1:0] exp);
    rd_req_i  = 1'b1;
    rd_addr_i = addr;
    step();
    rd_req_i  = 1'b0;
    chk({tag, "_v1"}, rd_valid_o, 0);
    step();
    chk({tag, "_v2"}, rd_valid_o, 1);
    chk({tag, "_d"}, rd_data_o, exp);
    step();
    chk({tag, "_v3"}, rd_valid_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int pulses;
    rst_n_i = 1'b0; data_i = '0; trig_i = '0; arm_i = 1'b0; abort_i = 1'b0;
    trig_mode_i = 2'd0; trig_mask_i = 1'b1; trig_value_i = 1'b1; pre_cnt_i = '0;
    rd_req_i = 1'b0; rd_addr_i = '0;

    // Reset
    step(); step();
    chk("rst_armed", armed_o, 0);
    chk("rst_trig", triggered_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_taddr", trig_addr_o, 0);
    chk("rst_rdv", rd_valid_o, 0);
    chk("rst_rdd", rd_data_o, 0);
    rst_n_i = 1'b1;
    rd_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_rd_ignored", rd_valid_o, 0);
    end
    rd_req_i = 1'b0;

    // Level trigger, pre_cnt=4, trigger at data 9
    do_arm(2'd0, 4'd4);
    chk("lvl_armed", armed_o, 1);
    for (int d = 0; d <= 20; d++) begin
      data_i = DATA_W'(d);
      trig_i = (d == 9);
      step();
      if (d == 8)  chk("lvl_trig_pre", triggered_o, 0);
      if (d == 9)  chk("lvl_trig", triggered_o, 1);
      if (d == 9)  chk("lvl_taddr", trig_addr_o, 9);
      if (d == 19) chk("lvl_done_early", done_o, 0);
      if (d == 20) chk("lvl_done", done_o, 1);
      if (d == 20) chk("lvl_armed_end", armed_o, 0);
    end
    trig_i = 1'b0;

    // Back-to-back reads 0..15: request j returns one step later, value 5+j
    pulses = 0;
    for (int j = 0; j < 18; j++) begin
      rd_req_i  = (j < 16);
      rd_addr_i = AW'(j);
      step();
      if (rd_valid_o) pulses++;
      if (j >= 1 && j <= 16) begin
        chk("b2b_vld", rd_valid_o, 1);
        chk("b2b_dat", rd_data_o, 5 + j - 1);
      end else begin
        chk("b2b_idle", rd_valid_o, 0);
      end
    end
    rd_req_i = 1'b0;
    chk("b2b_pulses", pulses, 16);

    // Rising mode, pre_cnt=0, trig high across arm, low for data 3..5, rises at 6
    trig_i = 1'b1;
    step();
    do_arm(2'd1, 4'd0);
    for (int d = 0; d <= 21; d++) begin
      data_i = DATA_W'(d);
      trig_i = !(d >= 3 && d < 6);
      step();
      if (d == 5)  chk("rise_trig_pre", triggered_o, 0);
      if (d == 6)  chk("rise_trig", triggered_o, 1);
      if (d == 6)  chk("rise_taddr", trig_addr_o, 6);
      if (d == 20) chk("rise_done_early", done_o, 0);
      if (d == 21) chk("rise_done", done_o, 1);
    end
    trig_i = 1'b0;
    rd_one("rise_rd0", 4'd0, 5'd6);
    rd_one("rise_rd15", 4'd15, 5'd21);

    // Immediate mode, pre_cnt=15: trigger on the first WAIT cycle, no POST
    do_arm(2'd3, 4'd15);
    for (int d = 0; d <= 15; d++) begin
      data_i = DATA_W'(d);
      step();
      if (d == 14) chk("imm_trig_pre", triggered_o, 0);
      if (d == 14) chk("imm_done_early", done_o, 0);
      if (d == 15) chk("imm_trig", triggered_o, 1);
      if (d == 15) chk("imm_taddr", trig_addr_o, 15);
      if (d == 15) chk("imm_done", done_o, 1);
    end
    rd_one("imm_rd15", 4'd15, 5'd15);
    rd_one("imm_rd0", 4'd0, 5'd0);

    // Abort during WAIT
    do_arm(2'd0, 4'd2);
    for (int d = 0; d < 4; d++) begin
      data_i = DATA_W'(d);
      step();
    end
    chk("abort_pre_armed", armed_o, 1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_armed", armed_o, 0);
    chk("abort_done", done_o, 0);

    // Arm and abort together: arm wins; then reads during POST are ignored
    abort_i = 1'b1;
    do_arm(2'd0, 4'd2);
    abort_i = 1'b0;
    chk("armabort_armed", armed_o, 1);
    for (int d = 0; d <= 18; d++) begin
      data_i   = DATA_W'(d);
      trig_i   = (d == 5);
      rd_req_i = (d >= 6);
      rd_addr_i = '0;
      step();
      if (d >= 6) chk("post_rd_ignored", rd_valid_o, 0);
      if (d == 5) chk("aa_taddr", trig_addr_o, 5);
      if (d == 18) chk("aa_done", done_o, 1);
    end
    rd_req_i = 1'b0;
    trig_i   = 1'b0;
    step();
    chk("post_rd_tail", rd_valid_o, 0);
    rd_one("aa_rd0", 4'd0, 5'd3);
    rd_one("aa_rd15", 4'd15, 5'd18);

    // A read in flight when arm arrives is dropped
    rd_req_i  = 1'b1;
    rd_addr_i = '0;
    step();
    rd_req_i  = 1'b0;
    do_arm(2'd3, 4'd0);
    chk("drop_rdv", rd_valid_o, 0);
    chk("drop_done", done_o, 0);
    chk("drop_trig", triggered_o, 0);
    chk("drop_armed", armed_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
